// File: rtl/load_frame_writer.sv
// Streams one frame of pixels into a frame buffer, then holds it until the
// consumer releases it. Tracks framing errors and completed frame count.
module load_frame_writer #(
    parameter int unsigned BIT_DEPTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [BIT_DEPTH-1:0]  s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BIT_DEPTH-1:0]  wr_data,
    output logic                  frame_ready,
    output logic                  frame_done,
    input  logic                  frame_release,
    output logic                  frame_err,
    output logic [7:0]            frame_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pix_addr;
    logic                    accept;
    logic                    at_last;
    logic                    complete;
    logic                    bad_frame;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: release is only honoured while holding a frame
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (complete)      state_next = HOLD;
            HOLD:    if (frame_release) state_next = LOAD;
            default:                    state_next = LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        s_ready = 1'b0;
        if (state == LOAD) begin
            s_ready = 1'b1;
        end
    end

    // Beat decode; a framing error is s_last disagreeing with the final address
    always_comb begin
        accept    = s_valid && s_ready;
        at_last   = (pix_addr == LAST_ADDR);
        complete  = accept && (at_last || s_last);
        bad_frame = accept && (s_last != at_last);
    end

    // Pixel address counter, restarted when the held frame is released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_addr <= '0;
        end else if (state == HOLD && frame_release) begin
            pix_addr <= '0;
        end else if (accept && !complete) begin
            pix_addr <= pix_addr + ADDR_WIDTH'(1);
        end
    end

    // Buffer write port; address and data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= pix_addr;
                wr_data <= s_data;
            end
        end
    end

    // Frame status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_ready <= (state_next == HOLD);
            frame_done  <= complete;
            frame_err   <= frame_err | bad_frame;
            if (complete) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_load_frame_writer.sv
// Randomised scoreboard bench for load_frame_writer against a frame-level model.
module tb_load_frame_writer;

    localparam int BD    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 784;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [BD-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BD-1:0] wr_data;
    logic          frame_ready;
    logic          frame_done;
    logic          frame_release;
    logic          frame_err;
    logic [7:0]    frame_count;

    load_frame_writer #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_ready(frame_ready), .frame_done(frame_done),
        .frame_release(frame_release), .frame_err(frame_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BD-1:0] d;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] done_q[$];
    wr_t        mon_w;
    logic [7:0] mon_c;

    // Frame-level model: holding flag, next pixel index, sticky error, frame tally
    bit            m_hold;
    int            m_idx;
    bit            m_err;
    int            m_count;
    bit            m_wr;
    bit            m_done;
    logic [AW-1:0] m_last_a;
    logic [BD-1:0] m_last_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_idx = 0; m_err = 0; m_count = 0;
        m_wr = 0; m_done = 0; m_last_a = '0; m_last_d = '0;
        wr_q.delete();
        done_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_s_ready", s_ready, 1);
    endtask

    // One clock: drive at negedge, model the edge, check at the next negedge
    task automatic cycle(input bit v, input logic [BD-1:0] d, input bit l, input bit rel);
        s_valid = v; s_data = d; s_last = l; frame_release = rel;
        @(posedge clk);
        m_wr = 0;
        m_done = 0;
        if (!m_hold) begin
            if (v) begin
                m_wr = 1;
                wr_q.push_back({AW'(m_idx), d});
                m_last_a = AW'(m_idx);
                m_last_d = d;
                if (l != (m_idx == DEPTH - 1)) m_err = 1;
                if (l || m_idx == DEPTH - 1) begin
                    m_hold  = 1;
                    m_done  = 1;
                    m_count = (m_count + 1) % 256;
                    done_q.push_back(8'(m_count));
                end else begin
                    m_idx++;
                end
            end
        end else if (rel) begin
            m_hold = 0;
            m_idx  = 0;
        end
        @(negedge clk);
        chk("s_ready", s_ready, !m_hold);
        chk("frame_ready", frame_ready, m_hold);
        chk("frame_done", frame_done, m_done);
        chk("frame_err", frame_err, m_err);
        chk("wr_en", wr_en, m_wr);
        if (!m_wr) begin
            chk("wr_addr_hold", wr_addr, m_last_a);
            chk("wr_data_hold", wr_data, m_last_d);
        end
    endtask

    task automatic drain();
        #1;
        chk("wr_q_empty", wr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random 70%
    task automatic send_frame(input int n_beats, input int last_at, input int mode,
                              input bit rand_data, input bit rand_rel);
        int sent = 0;
        int cyc  = 0;
        while (sent < n_beats && cyc < 20000) begin
            bit v;
            bit l;
            bit rel;
            logic [BD-1:0] d;
            case (mode)
                0:       v = 1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(99) < 70);
            endcase
            d   = rand_data ? BD'($urandom) : BD'(sent);
            l   = v ? (sent == last_at) : 1'($urandom);
            rel = rand_rel && ($urandom_range(3) == 0);
            cycle(v, d, l, rel);
            if (v) sent++;
            cyc++;
        end
        if (sent < n_beats) chk("send_timeout", sent, n_beats);
    endtask

    task automatic hold_release(input int hold_cycles);
        repeat (hold_cycles) cycle(1'b1, BD'($urandom), 1'($urandom), 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic reset_now();
        #2;
        rst = 1'b1;
        s_valid = 1'b0; s_last = 1'b0; frame_release = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every write and every frame_done pops an expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {22'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_addr", wr_addr, mon_w.a);
                    chk("wr_data", wr_data, mon_w.d);
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", frame_count, 32'hFFFF_FFFF);
                end else begin
                    mon_c = done_q.pop_front();
                    chk("frame_count", frame_count, mon_c);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; frame_release = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full frame, data = address, s_last on the final beat
        send_frame(DEPTH, DEPTH - 1, 0, 1'b0, 1'b0);
        drain();
        chk("full_count", frame_count, 1);
        chk("full_err", frame_err, 0);

        // Backpressure in HOLD, then release; next frame throttled with stray releases
        hold_release(3);
        send_frame(DEPTH, DEPTH - 1, 1, 1'b1, 1'b1);
        drain();
        chk("throttle_count", frame_count, 2);
        hold_release(1);

        // Reset part-way through a frame
        send_frame(400, -1, 0, 1'b1, 1'b0);
        reset_now();

        // Missing s_last on the final beat still completes, but flags an error
        send_frame(DEPTH, -1, 0, 1'b0, 1'b0);
        drain();
        chk("missing_last_err", frame_err, 1);
        chk("missing_last_count", frame_count, 1);
        hold_release(0);

        // Early s_last on beat 99
        reset_now();
        send_frame(100, 99, 0, 1'b1, 1'b0);
        drain();
        chk("early_last_addr", wr_addr, 99);
        chk("early_err", frame_err, 1);
        chk("early_count", frame_count, 1);
        chk("early_ready", frame_ready, 1);
        hold_release(2);

        // Random frames: random throttling, random early termination, stray releases
        for (int f = 0; f < 4; f++) begin
            int la;
            la = ($urandom_range(1) == 0) ? DEPTH - 1 : int'($urandom_range(DEPTH - 1));
            send_frame(la + 1, la, 2, 1'b1, 1'b1);
            drain();
            hold_release(int'($urandom_range(3)));
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
